// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built from one full-adder cell and a
// carry flip-flop. It processes one operand bit per clock, least significant bit
// first, so a WIDTH-bit operation takes WIDTH cycles in ADD.
//
// Ports
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - begin an operation (accepted in IDLE or DONE, ignored while busy)
//   SUB   - 0: A+B+CIN, 1: A-B (A + ~B + 1, CIN ignored); captured with start
//   A, B  - operands, captured with start
//   CIN   - carry-in for add mode, captured with start
//   S     - result register (partially shifted while busy)
//   COUT  - final carry-out (in subtract mode 1 means no borrow)
//   V     - signed overflow: carry into MSB xor carry out of MSB
//   busy  - operation in progress
//   done  - one-cycle pulse when S/COUT/V are valid
//
// state | meaning
// IDLE  | waiting for start, results held
// ADD   | one bit per cycle, counter selects the current bit
// DONE  | results valid for one cycle, start accepted back-to-back

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    logic sum_bit;
    logic carry_next;

    assign sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        v_d     = v_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction reuses the adder: invert B and force carry-in to 1.
                    a_d     = A;
                    b_d     = B ^ {WIDTH{SUB}};
                    carry_d = SUB ? 1'b1 : CIN;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (cnt_q > LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    s_d     = {sum_bit, s_q[WIDTH-1:1]};
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    carry_d = carry_next;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // carry_q here is the carry into the MSB.
                        cout_d  = carry_next;
                        v_d     = carry_q ^ carry_next;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign S    = s_q;
    assign COUT = cout_q;
    assign V    = v_q;
    assign busy = (state_q == ST_ADD);
    assign done = (state_q == ST_DONE);

endmodule
